note_frame_sched: RTL and testbench
===================================

NOTE_FRAME_SCHED -- requirements
Module: note_frame_sched

Interface
REQ-001 Parameter: DEPTH, default 4, note-update FIFO depth in entries (power of 2, 2..8).
REQ-002 Parameter: HOLD_FRAMES, default 6, minimum frames a lit note stays lit (1..7).
REQ-003 Port: vgaclk  input  1  pixel clock; sole clock; all state on its rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: vsync  input  1  active-low vertical sync from the VGA timing controller, same clock domain.
REQ-006 Port: upd_valid  input  1  producer has a note mask on upd_notes.
REQ-007 Port: upd_notes  input  8  requested note mask; bit7 is the lowest scale note, bit0 the highest; 1 means on.
REQ-008 Port: upd_ready  output  1  FIFO can accept an entry.
REQ-009 Port: notes  output  8  displayed note mask driven to the pixel generator; registered.
REQ-010 Port: pending  output  4  current FIFO occupancy, 0..DEPTH.

Function
REQ-011 Frame start (FS) is the single cycle where registered vsync_q=1 and vsync=0 (the vsync falling edge).
REQ-012 upd_ready = (pending < DEPTH); a push occurs in any cycle with upd_valid & upd_ready; FIFO is first-in, first-out.
REQ-013 FSM states: IDLE (FIFO empty), WAIT (FIFO non-empty, awaiting FS), APPLY (one cycle, pops head).
REQ-014 Transitions: IDLE->WAIT when pending becomes nonzero; WAIT->APPLY on FS; APPLY->WAIT if entries remain after the pop, else IDLE; an FS in IDLE has no FIFO effect.
REQ-015 At most one entry is consumed per frame; surplus entries wait for later FSs in order.
REQ-016 Push and pop in the same APPLY cycle leave pending unchanged; push is never accepted when full.
REQ-017 Each note i has a 3-bit hold counter hold[i] and a deferred-off flag doff[i].
REQ-018 On FS, every nonzero hold[i] decrements by 1; if hold[i] goes 1->0 and doff[i]=1, notes[i] clears and doff[i] clears at the edge ending FS.
REQ-019 In APPLY with head mask m, for each bit i: m[i]=1 and notes[i]=0 -> notes[i]=1, hold[i]=HOLD_FRAMES-1, doff[i]=0.
REQ-020 m[i]=1 and notes[i]=1 -> notes[i] stays 1, hold[i] unchanged, doff[i]=0.
REQ-021 m[i]=0 and notes[i]=1 -> notes[i]=0 if hold[i]=0, else notes[i] stays 1 and doff[i]=1.
REQ-022 m[i]=0 and notes[i]=0 -> no change.
REQ-023 Latency: an entry at the FIFO head at FS is reflected on notes at FS+2 cycles; deferred offs take effect at FS+1.
REQ-024 With HOLD_FRAMES=1 the hold counter loads 0 and note-offs take effect immediately in APPLY.
REQ-025 notes changes only at FS+1 or FS+2, never mid-frame, so the displayed image stays tear-free.

Reset
REQ-026 While reset_n=0: notes=0, FIFO empty, pending=0, upd_ready=1, state IDLE, all hold=0, all doff=0, vsync_q=1.
REQ-027 Reset asserted mid-frame or mid-APPLY discards all queued entries; the first FS after release applies nothing.

Verification
REQ-028 Push 8'hA5 in IDLE, then FS -> state APPLY at FS+1; notes=8'hA5 at FS+2; pending=0; state IDLE.
REQ-029 Push 8'h80, FS; then push 8'h00 and FS -> notes stays 8'h80 (doff[7]=1); after 5 total FSs from the first apply, notes=8'h00.
REQ-030 Five back-to-back pushes with DEPTH=4 and no FS -> upd_ready=0 after the 4th push; 5th held; pending=4; 1 pop per FS drains in 4 frames in order.
REQ-031 Push while full during APPLY -> push accepted only when pending<DEPTH at that cycle; pending=3 with push+pop stays 3.
REQ-032 Set notes=8'hFF, push 8'h00, assert reset_n=0 for 1 cycle mid-frame -> notes=0, pending=0; the next FS leaves notes=0.
REQ-033 Off request for a held note, then re-on before expiry -> doff cleared; note remains lit past hold expiry.

Source files
------------

// File: rtl/note_frame_sched.sv
// note_frame_sched: queues note-mask updates and applies one per frame at vsync fall, with per-note minimum hold
//   vgaclk/reset_n : pixel clock, async active-low reset
//   vsync          : active-low vertical sync; its falling edge marks frame start
//   upd_valid/upd_notes/upd_ready : producer handshake for 8-bit note masks (bit7 = lowest note)
//   notes          : registered displayed mask, changes only just after frame start
//   pending        : FIFO occupancy
module note_frame_sched #(
  parameter int DEPTH = 4,
  parameter int HOLD_FRAMES = 6
) (
  input  logic       vgaclk,
  input  logic       reset_n,
  input  logic       vsync,
  input  logic       upd_valid,
  input  logic [7:0] upd_notes,
  output logic       upd_ready,
  output logic [7:0] notes,
  output logic [3:0] pending
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] HLOAD = 3'(HOLD_FRAMES - 1);
  typedef enum logic [1:0] {IDLE, WAIT, APPLY} state_t;
  state_t state, state_nx;
  logic vsync_q, fs, push, pop;
  logic [7:0] mem [DEPTH];
  logic [7:0] head, doff;
  logic [AW-1:0] wp, rp;
  logic [2:0] hold [8];
  assign fs = vsync_q & ~vsync;
  assign upd_ready = pending < 4'(DEPTH);
  assign push = upd_valid & upd_ready;
  assign pop = state == APPLY;
  assign head = mem[rp];
  // APPLY always pops, so entries remain unless the last one leaves without a refill
  always_comb begin
    state_nx = state == IDLE  ? (push ? WAIT : IDLE) :
               state == WAIT  ? (fs ? APPLY : WAIT) :
               state == APPLY ? ((pending != 4'd1 || push) ? WAIT : IDLE) : IDLE;
  end
  always_ff @(posedge vgaclk)
    if (push) mem[wp] <= upd_notes;
  always_ff @(posedge vgaclk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q <= 1'b1;
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      pending <= '0;
      notes <= '0;
      doff <= '0;
      for (int i = 0; i < 8; i++) hold[i] <= '0;
    end else begin
      vsync_q <= vsync;
      state <= state_nx;
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      pending <= pending + 4'(push) - 4'(pop);
      for (int i = 0; i < 8; i++) begin
        // hold ticks down once per frame; a deferred off fires as it expires
        if (fs && hold[i] != 3'd0) begin
          hold[i] <= hold[i] - 3'd1;
          if (hold[i] == 3'd1 && doff[i]) begin
            notes[i] <= 1'b0;
            doff[i] <= 1'b0;
          end
        end
        if (pop) begin
          if (head[i] && !notes[i]) begin
            notes[i] <= 1'b1;
            hold[i] <= HLOAD;
            doff[i] <= 1'b0;
          end else if (head[i]) doff[i] <= 1'b0;
          else if (notes[i]) begin
            if (hold[i] == 3'd0) notes[i] <= 1'b0;
            else doff[i] <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_note_frame_sched.sv
// tb_note_frame_sched: table plus hand sequences with an expected-notes queue for note_frame_sched
module tb_note_frame_sched;
  logic vgaclk = 1'b0;
  logic reset_n = 1'b0;
  logic vsync = 1'b1;
  logic upd_valid = 1'b0;
  logic [7:0] upd_notes = '0;
  logic upd_ready;
  logic [7:0] notes;
  logic [3:0] pending;
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q [$];
  typedef struct {logic [7:0] mask; logic [7:0] exp;} vec_t;
  vec_t tbl [9];

  note_frame_sched dut (
    .vgaclk(vgaclk), .reset_n(reset_n), .vsync(vsync), .upd_valid(upd_valid),
    .upd_notes(upd_notes), .upd_ready(upd_ready), .notes(notes), .pending(pending)
  );

  always #5 vgaclk = ~vgaclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%h req=%h", name, act, exp);
    end
  endtask

  task automatic chk_notes(input string name);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: act=%h req=queue_empty", name, notes);
    end else chk(name, notes, exp_q.pop_front());
  endtask

  task automatic push(input logic [7:0] m);
    @(negedge vgaclk);
    upd_valid = 1'b1;
    upd_notes = m;
    @(negedge vgaclk);
    upd_valid = 1'b0;
  endtask

  task automatic frame();
    @(negedge vgaclk) vsync = 1'b0;
    repeat (2) @(negedge vgaclk);
    vsync = 1'b1;
    repeat (4) @(negedge vgaclk);
  endtask

  task automatic do_reset();
    @(negedge vgaclk) reset_n = 1'b0;
    repeat (2) @(negedge vgaclk);
    reset_n = 1'b1;
    @(negedge vgaclk);
  endtask

  initial begin
    tbl[0] = '{8'hA5, 8'hA5};
    tbl[1] = '{8'hFF, 8'hFF};
    tbl[2] = '{8'h00, 8'hFF};
    tbl[3] = '{8'hFF, 8'hFF};
    tbl[4] = '{8'h00, 8'hFF};
    tbl[5] = '{8'h00, 8'h5A};
    tbl[6] = '{8'h00, 8'h00};
    tbl[7] = '{8'h81, 8'h81};
    tbl[8] = '{8'h01, 8'h81};
    repeat (2) @(negedge vgaclk);
    chk("rst_notes", notes, 8'h00);
    chk("rst_pending", 8'(pending), 8'd0);
    chk("rst_ready", 8'(upd_ready), 8'd1);
    reset_n = 1'b1;
    @(negedge vgaclk);
    // main table: one entry per frame, notes checked after FS+2
    for (int k = 0; k < 9; k++) begin
      push(tbl[k].mask);
      exp_q.push_back(tbl[k].exp);
      chk($sformatf("tbl%0d_pend1", k), 8'(pending), 8'd1);
      frame();
      chk_notes($sformatf("tbl%0d_notes", k));
      chk($sformatf("tbl%0d_pend0", k), 8'(pending), 8'd0);
    end
    // FS with empty FIFO changes nothing
    frame();
    chk("idle_fs_notes", notes, 8'h81);
    // notes unchanged at FS+1, updated at FS+2
    do_reset();
    push(8'h3C);
    @(negedge vgaclk) vsync = 1'b0;
    @(negedge vgaclk);
    chk("lat_fs1", notes, 8'h00);
    @(negedge vgaclk);
    chk("lat_fs2", notes, 8'h3C);
    vsync = 1'b1;
    repeat (3) @(negedge vgaclk);
    // overflow: four accepted, fifth held
    do_reset();
    for (int k = 0; k < 4; k++) push(8'h01 << k);
    chk("full_pend", 8'(pending), 8'd4);
    chk("full_ready", 8'(upd_ready), 8'd0);
    @(negedge vgaclk);
    upd_valid = 1'b1;
    upd_notes = 8'h10;
    @(negedge vgaclk);
    chk("fifth_held", 8'(pending), 8'd4);
    upd_valid = 1'b0;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h07);
    exp_q.push_back(8'h0F);
    for (int k = 0; k < 4; k++) begin
      frame();
      chk_notes($sformatf("drain%0d_notes", k));
      chk($sformatf("drain%0d_pend", k), 8'(pending), 8'(3 - k));
    end
    // push attempt while full during APPLY
    for (int k = 0; k < 4; k++) push(8'h11 << (k % 2));
    @(negedge vgaclk) vsync = 1'b0;
    @(negedge vgaclk);
    vsync = 1'b1;
    upd_valid = 1'b1;
    upd_notes = 8'h99;
    chk("apply_full_ready", 8'(upd_ready), 8'd0);
    @(negedge vgaclk);
    chk("apply_full_pend", 8'(pending), 8'd3);
    @(negedge vgaclk);
    upd_valid = 1'b0;
    chk("refill_pend", 8'(pending), 8'd4);
    frame();
    chk("pop_pend", 8'(pending), 8'd3);
    // push and pop together at pending=3
    @(negedge vgaclk) vsync = 1'b0;
    @(negedge vgaclk);
    vsync = 1'b1;
    upd_valid = 1'b1;
    upd_notes = 8'h42;
    chk("apply3_ready", 8'(upd_ready), 8'd1);
    @(negedge vgaclk);
    upd_valid = 1'b0;
    chk("pushpop_pend", 8'(pending), 8'd3);
    // reset mid-frame discards queued entries
    do_reset();
    push(8'hFF);
    frame();
    chk("pre_rst_notes", notes, 8'hFF);
    push(8'h00);
    @(negedge vgaclk) reset_n = 1'b0;
    #1;
    chk("mid_rst_notes", notes, 8'h00);
    chk("mid_rst_pend", 8'(pending), 8'd0);
    chk("mid_rst_ready", 8'(upd_ready), 8'd1);
    @(negedge vgaclk) reset_n = 1'b1;
    frame();
    chk("post_rst_notes", notes, 8'h00);
    chk("post_rst_pend", 8'(pending), 8'd0);
    // off then re-on before expiry keeps the note lit
    push(8'h80);
    frame();
    push(8'h00);
    frame();
    chk("doff_held", notes, 8'h80);
    push(8'h80);
    frame();
    repeat (5) frame();
    chk("reon_kept", notes, 8'h80);
    // a lone off on the same note now retires at the next FS (hold already 0)
    push(8'h00);
    frame();
    chk("expired_off", notes, 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
